alu_sequencer: RTL

Request/response front-end driving the datapath ALU through one complete operation: operand/opcode presentation, the execute-enable pulse, and the bus read-back of BR (via C9) and optionally MR (via C10). It sits between the control unit or accumulator logic and the ALU. It returns the 16-bit low result, the optional high result and the 5-bit flag vector on a valid/ready response port. It owns every ALU control input, so no other block may drive `ctrl_alu_en`, C9 or C10.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_sequencer.sv | 109 ++++++++++
 2 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, flag bit positions and the sequencer state encoding.
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_MPY = 3'd2;
  localparam logic [2:0] ALU_AND = 3'd3;
  localparam logic [2:0] ALU_OR  = 3'd4;
  localparam logic [2:0] ALU_NOT = 3'd5;
  localparam logic [2:0] ALU_SHR = 3'd6;
  localparam logic [2:0] ALU_SHL = 3'd7;

  localparam int unsigned FLAG_ZF = 4;
  localparam int unsigned FLAG_CF = 3;
  localparam int unsigned FLAG_OF = 2;
  localparam int unsigned FLAG_NF = 1;
  localparam int unsigned FLAG_MF = 0;

  typedef enum logic [2:0] {
    StIdle,
    StExec,
    StRdLo,
    StRdHi,
    StResp
  } seq_state_e;

endpackage

// File: rtl/alu_sequencer.sv
// Drives one ALU operation end to end: latch request, pulse execute, read BR (and MR), respond.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_req_valid,
  output logic             o_req_ready,
  input  logic [2:0]       i_req_op,
  input  logic [WIDTH-1:0] i_req_p,
  input  logic [WIDTH-1:0] i_req_q,
  input  logic             i_req_rd_high,
  output logic [WIDTH-1:0] o_acc_alu_p,
  output logic [WIDTH-1:0] o_acc_alu_q,
  output logic [2:0]       o_ctrl_alu_op,
  output logic             o_ctrl_alu_en,
  output logic             o_C9,
  output logic             o_C10,
  input  logic [WIDTH-1:0] i_br,
  input  logic [WIDTH-1:0] i_mr,
  input  logic [4:0]       i_flags,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic [WIDTH-1:0] o_rsp_low,
  output logic [WIDTH-1:0] o_rsp_high,
  output logic [4:0]       o_rsp_flags
);

  seq_state_e       state_q, state_d;
  logic [WIDTH-1:0] p_q, q_q, rsp_low_q, rsp_high_q;
  logic [2:0]       op_q;
  logic             rd_high_q;
  logic [4:0]       rsp_flags_q;
  logic             accept;

  assign accept = i_req_valid && (state_q == StIdle);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= StIdle;
      p_q         <= '0;
      q_q         <= '0;
      op_q        <= '0;
      rd_high_q   <= 1'b0;
      rsp_low_q   <= '0;
      rsp_high_q  <= '0;
      rsp_flags_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        p_q        <= i_req_p;
        q_q        <= i_req_q;
        op_q       <= i_req_op;
        rd_high_q  <= i_req_rd_high;
        // Cleared here so a skipped MR read reports zero.
        rsp_high_q <= '0;
      end
      if (state_q == StRdLo) begin
        rsp_low_q   <= i_br;
        rsp_flags_q <= i_flags;
      end
      if (state_q == StRdHi) begin
        rsp_high_q <= i_mr;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    o_req_ready   = 1'b0;
    o_ctrl_alu_en = 1'b0;
    o_C9          = 1'b0;
    o_C10         = 1'b0;
    o_rsp_valid   = 1'b0;
    unique case (state_q)
      StIdle: begin
        o_req_ready = 1'b1;
        if (i_req_valid) state_d = StExec;
      end
      StExec: begin
        o_ctrl_alu_en = 1'b1;
        state_d       = StRdLo;
      end
      StRdLo: begin
        o_C9    = 1'b1;
        state_d = ((op_q == ALU_MPY) || rd_high_q) ? StRdHi : StResp;
      end
      StRdHi: begin
        o_C10   = 1'b1;
        state_d = StResp;
      end
      StResp: begin
        o_rsp_valid = 1'b1;
        if (i_rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign o_acc_alu_p   = p_q;
  assign o_acc_alu_q   = q_q;
  assign o_ctrl_alu_op = op_q;
  assign o_rsp_low     = rsp_low_q;
  assign o_rsp_high    = rsp_high_q;
  assign o_rsp_flags   = rsp_flags_q;

endmodule
